// File: rtl/alu_n_bit_seq.sv
// ---------------------------------------------------------------------------
// alu_n_bit_seq
//
// Sequential N-bit ALU with a valid/ready request handshake. Single-cycle ops
// (AND, OR, ADD, SUB, SLT, NOR) produce their registered result one cycle
// after accept. The optional MUL is an iterative shift-add multiplier that
// retires one multiplier bit per cycle and produces a 2*WIDTH product.
//
// Build option:
//   ALU_SEQ_MUL_EN  defined   -> MUL (ALUop 1000) is implemented
//                   undefined -> 1000 is an undefined op, result_hi tied to 0
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   A, B       operands (WIDTH bits)
//   C          carry-in, used by ADD only
//   ALUop      operation select (4 bits)
//   in_valid   request strobe, accepted when in_valid && in_ready
//   in_ready   high when a request can be accepted (IDLE only)
//   result     registered result (low half of the product for MUL)
//   result_hi  high half of the MUL product, 0 for all other ops
//   carryout   carry out of the MSB for ADD/SUB
//   overflow   signed overflow for ADD/SUB
//   zero       result (and result_hi) equal to zero
//   illegal    accepted ALUop was undefined
//   out_valid  one-cycle pulse when the result outputs are updated
// ---------------------------------------------------------------------------
module alu_n_bit_seq #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic [3:0]       ALUop,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic             out_valid
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1
`ifdef ALU_SEQ_MUL_EN
    ,
    ST_MUL  = 2'd2
`endif
  } state_t;

  state_t state, next_state;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_illegal;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     upper_sum;
  logic [CW-1:0]      cnt;

  assign is_mul = (ALUop == OP_MUL);

  // Shift-add step: the upper half of prod is the accumulator, the lower
  // half holds the not-yet-consumed multiplier bits (LSB first). After
  // WIDTH steps prod holds the full product.
  assign upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                   + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign prod_next = {upper_sum, prod[WIDTH-1:1]};
`else
  assign is_mul    = 1'b0;
  assign result_hi = '0;
`endif

  assign sum_ext  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C};
  assign diff_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle ALU ops; anything not decoded here is flagged illegal.
  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (ALUop)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR: alu_res = ~(A | B);
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          next_state = is_mul ? ST_MUL : ST_DONE;
`else
          next_state = ST_DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL:  if (cnt == LAST_STEP) next_state = ST_DONE;
`endif
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Result registers only change when a result is produced, so they hold
  // their previous values through a multiply until its final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      illegal  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      result_hi <= '0;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
`endif
    end else if (accept && !is_mul) begin
      result   <= alu_res;
      carryout <= alu_carry;
      overflow <= alu_ovf;
      illegal  <= alu_illegal;
      zero     <= (alu_res == '0);
`ifdef ALU_SEQ_MUL_EN
      result_hi <= '0;
    end else if (accept) begin
      mcand <= A;
      prod  <= {{WIDTH{1'b0}}, B};
      cnt   <= '0;
    end else if (state == ST_MUL) begin
      prod <= prod_next;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST_STEP) begin
        result    <= prod_next[WIDTH-1:0];
        result_hi <= prod_next[2*WIDTH-1:WIDTH];
        carryout  <= 1'b0;
        overflow  <= 1'b0;
        illegal   <= 1'b0;
        zero      <= (prod_next == '0);
      end
`endif
    end
  end

endmodule
